fifo_bank: RTL and testbench
============================

// Module: fifo_bank
// PURPOSE
//   Parametrised bank of NPORT independent input FIFOs for a NoC router port group.
//   Generalises the fixed three-channel router buffer: channel count is a parameter and buses are packed.
//   Adds almost-full flags, write-through-on-full, and saturating per-channel drop counters.
//   Sits between link inputs and the router crossbar/arbiter; pressure feeds adaptive routing.
// PARAMETERS
//   NPORT     3   number of independent channels
//   DEPTH     8   entries per channel; must equal 2**WIDTH
//   WIDTH     3   pointer width; count/pressure is WIDTH+1 bits
//   DATASIZE  40  flit width in bits
//   AFULL_TH  6   almost-full threshold; afull asserted when count >= AFULL_TH (1..DEPTH)
//   CNTW      8   drop-counter width
// PORTS
//   fifo_clk      in   1                  single clock, all state on rising edge
//   rst_n         in   1                  asynchronous, active-low reset
//   data_in       in   NPORT*DATASIZE     channel i at [i*DATASIZE +: DATASIZE]
//   valid_in      in   NPORT              write request per channel
//   ready_in      in   NPORT              read request (pop) from downstream per channel
//   data_out      out  NPORT*DATASIZE     head flit per channel (show-ahead)
//   valid_out     out  NPORT              channel non-empty (head valid)
//   full_out      out  NPORT              count == DEPTH
//   afull_out     out  NPORT              count >= AFULL_TH
//   pressure_out  out  NPORT*(WIDTH+1)    occupancy count, channel i at [i*(WIDTH+1) +: WIDTH+1]
//   drop_cnt      out  NPORT*CNTW         saturating count of rejected writes
// BEHAVIOUR
//   - Reset (async assert, sync-released use): ptrs=0, count=0, drop_cnt=0; valid_out=0, full_out=0,
//     afull_out=0, pressure_out=0; data_out don't-care (memory not reset).
//   - Channels fully independent; no shared state.
//   - pop = ready_in & valid_out; ready_in on empty channel ignored, no pointer move.
//   - push = valid_in & (!full | pop); full channel popped same cycle accepts write (count unchanged).
//   - push&pop: count unchanged, both pointers advance; non-full, non-empty case likewise.
//   - Pointers WIDTH bits, wrap DEPTH-1 -> 0 naturally.
//   - data_out = mem[rd_ptr] combinationally; head visible the cycle after write (1-cycle latency).
//   - valid_out/full_out/afull_out/pressure_out derived from registered count; no combinational
//     path from valid_in/ready_in to these flags.
//   - drop: valid_in & full & !pop -> flit discarded, drop_cnt++ saturating at 2**CNTW-1.
//   - Reset mid-operation: all queued flits lost, outputs return to reset values immediately.
// CONFIGURATION
//   FIFO_BANK_BYPASS_EN defined: when channel empty and valid_in=1, valid_out=1 and data_out=data_in
//     the same cycle; if ready_in also 1 the flit passes through and is not stored (count stays 0);
//     otherwise stored as normal. Creates comb path valid_in/data_in -> valid_out/data_out.
//   Undefined: no bypass; empty channel shows valid_out=0 until cycle after the write.
// TESTING
//   1 reset: rst_n=0 mid-traffic -> all valid_out/full_out/afull_out=0, pressure=0, drop_cnt=0.
//   2 fill ch0 with 8 flits 0x01..0x08, ready_in=0 -> afull_out[0]=1 after 6th, full_out[0]=1
//     after 8th, pressure=8; other channels unaffected; drain yields 0x01..0x08 in order.
//   3 ch1 full, valid_in=1 & ready_in=1 same cycle with 0xAA -> pops head, 0xAA stored,
//     pressure stays 8, drop_cnt[1]=0.
//   4 ch2 full, ready_in=0, 300 writes -> drop_cnt[2] saturates at 255, contents unchanged.
//   5 10 push/pop cycles at count=1 -> pointers wrap past 7, data order preserved, count stays 1.
//   6 bypass on: empty ch0, valid_in=1, data 0x55, ready_in=1 -> data_out=0x55, valid_out=1 same
//     cycle, pressure stays 0; bypass off: valid_out=0 that cycle, 0x55 appears next cycle.

Source files
------------

// File: rtl/fifo_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_bank : NPORT independent show-ahead input FIFOs with almost-full,     |
// |             write-through-on-full and saturating per-channel drop counts.  |
// | Option    : FIFO_BANK_BYPASS_EN enables empty-channel cut-through.         |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module fifo_bank #(
  parameter int NPORT    = 3,
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 3,
  parameter int DATASIZE = 40,
  parameter int AFULL_TH = 6,
  parameter int CNTW     = 8
) (
  input  logic                         fifo_clk,
  input  logic                         rst_n,
  input  logic [NPORT*DATASIZE-1:0]    data_in,
  input  logic [NPORT-1:0]             valid_in,
  input  logic [NPORT-1:0]             ready_in,
  output logic [NPORT*DATASIZE-1:0]    data_out,
  output logic [NPORT-1:0]             valid_out,
  output logic [NPORT-1:0]             full_out,
  output logic [NPORT-1:0]             afull_out,
  output logic [NPORT*(WIDTH+1)-1:0]   pressure_out,
  output logic [NPORT*CNTW-1:0]        drop_cnt
);

  localparam logic [WIDTH:0] c_DEPTH = (WIDTH+1)'(DEPTH);
  localparam logic [WIDTH:0] c_AFULL = (WIDTH+1)'(AFULL_TH);

  for (genvar ch = 0; ch < NPORT; ch++) begin : g_ch
    logic [DATASIZE-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0]    r_wr_ptr;
    logic [WIDTH-1:0]    r_rd_ptr;
    logic [WIDTH:0]      r_count;
    logic [CNTW-1:0]     r_drop;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic                w_pass;
    logic [DATASIZE-1:0] w_din;

    assign w_din   = data_in[ch*DATASIZE +: DATASIZE];
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_DEPTH);
    assign w_pop   = ready_in[ch] & ~w_empty;

`ifdef FIFO_BANK_BYPASS_EN
    // Flit accepted on an empty channel while downstream is ready never touches memory.
    assign w_pass                               = w_empty & valid_in[ch] & ready_in[ch];
    assign valid_out[ch]                        = ~w_empty | valid_in[ch];
    assign data_out[ch*DATASIZE +: DATASIZE]    = w_empty ? w_din : r_mem[r_rd_ptr];
`else
    assign w_pass                               = 1'b0;
    assign valid_out[ch]                        = ~w_empty;
    assign data_out[ch*DATASIZE +: DATASIZE]    = r_mem[r_rd_ptr];
`endif

    assign w_push = valid_in[ch] & (~w_full | w_pop) & ~w_pass;
    assign w_drop = valid_in[ch] & w_full & ~w_pop;

    assign full_out[ch]                         = w_full;
    assign afull_out[ch]                        = (r_count >= c_AFULL);
    assign pressure_out[ch*(WIDTH+1) +: WIDTH+1] = r_count;
    assign drop_cnt[ch*CNTW +: CNTW]            = r_drop;

    always_ff @(posedge fifo_clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_drop   <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
        if (w_drop && (r_drop != '1)) r_drop <= r_drop + 1'b1;
      end
    end

    always_ff @(posedge fifo_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_din;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_bank.sv
`default_nettype none
// Testbench for fifo_bank: hand-tabulated fill/drain vectors, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_fifo_bank;
  localparam int NP = 3, DW = 40, PW = 4, CW = 8, DEPTH = 8, AF = 6;
`ifdef FIFO_BANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NP*DW-1:0]  din = '0;
  logic [NP-1:0]     vin = '0;
  logic [NP-1:0]     rin = '0;
  logic [NP*DW-1:0]  data_out;
  logic [NP-1:0]     valid_out, full_out, afull_out;
  logic [NP*PW-1:0]  pressure_out;
  logic [NP*CW-1:0]  drop_cnt;

  fifo_bank dut (
    .fifo_clk(clk), .rst_n(rst_n), .data_in(din), .valid_in(vin), .ready_in(rin),
    .data_out(data_out), .valid_out(valid_out), .full_out(full_out),
    .afull_out(afull_out), .pressure_out(pressure_out), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  logic [DW-1:0] q [NP][$];
  int drops [NP];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NP*DW-1:0] put(input int c, input logic [DW-1:0] v);
    logic [NP*DW-1:0] r;
    r = '0;
    r[c*DW +: DW] = v;
    return r;
  endfunction

  task automatic check_model(input string tag);
    for (int c = 0; c < NP; c++) begin
      int sz;
      logic ev;
      sz = q[c].size();
      ev = (sz > 0) || (BYP && vin[c]);
      chk($sformatf("%s_valid%0d", tag, c), 64'(valid_out[c]), 64'(ev));
      if (ev) chk($sformatf("%s_data%0d", tag, c), 64'(data_out[c*DW +: DW]),
                  64'((sz > 0) ? q[c][0] : din[c*DW +: DW]));
      chk($sformatf("%s_full%0d", tag, c), 64'(full_out[c]), 64'(sz == DEPTH));
      chk($sformatf("%s_afull%0d", tag, c), 64'(afull_out[c]), 64'(sz >= AF));
      chk($sformatf("%s_press%0d", tag, c), 64'(pressure_out[c*PW +: PW]), 64'(sz));
      chk($sformatf("%s_drop%0d", tag, c), 64'(drop_cnt[c*CW +: CW]), 64'(drops[c]));
    end
  endtask

  task automatic model_update();
    for (int c = 0; c < NP; c++) begin
      int sz;
      logic [DW-1:0] tmp;
      sz = q[c].size();
      if (!(BYP && sz == 0 && vin[c] && rin[c])) begin
        if (rin[c] && sz > 0) tmp = q[c].pop_front();
        if (vin[c] && (sz < DEPTH || rin[c])) q[c].push_back(din[c*DW +: DW]);
        else if (vin[c]) drops[c] = (drops[c] >= 255) ? 255 : drops[c] + 1;
      end
    end
  endtask

  task automatic step(input logic [NP-1:0] v, input logic [NP-1:0] r, input logic [NP*DW-1:0] d);
    vin = v; rin = r; din = d;
    #2;
    check_model("step");
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 64'(valid_out), 64'(0));
    chk({tag, "_full"}, 64'(full_out), 64'(0));
    chk({tag, "_afull"}, 64'(afull_out), 64'(0));
    chk({tag, "_press"}, 64'(pressure_out), 64'(0));
    chk({tag, "_drop"}, 64'(drop_cnt), 64'(0));
  endtask

  function automatic logic [NP*DW-1:0] rand_data();
    logic [NP*DW-1:0] r;
    for (int c = 0; c < NP; c++) r[c*DW +: DW] = DW'({$urandom, $urandom});
    return r;
  endfunction

  typedef struct {
    logic          v;
    logic          r;
    logic [DW-1:0] d;
    int            exp_p;
    logic          exp_af;
    logic          exp_f;
    logic          exp_v;
    logic [DW-1:0] exp_h;
  } vec_t;
  vec_t tbl [16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fill ch0 with 0x01..0x08, then drain; expectations observed just after each edge.
    for (int i = 0; i < 8; i++) begin
      tbl[i].v = 1'b1; tbl[i].r = 1'b0; tbl[i].d = DW'(i + 1);
      tbl[i].exp_p = i + 1; tbl[i].exp_af = ((i + 1) >= AF); tbl[i].exp_f = ((i + 1) == DEPTH);
      tbl[i].exp_v = 1'b1; tbl[i].exp_h = DW'(1);
    end
    for (int j = 0; j < 8; j++) begin
      tbl[8+j].v = 1'b0; tbl[8+j].r = 1'b1; tbl[8+j].d = '0;
      tbl[8+j].exp_p = 7 - j; tbl[8+j].exp_af = ((7 - j) >= AF); tbl[8+j].exp_f = 1'b0;
      tbl[8+j].exp_v = ((7 - j) > 0); tbl[8+j].exp_h = DW'(j + 2);
    end
    for (int c = 0; c < NP; c++) drops[c] = 0;

    #3;
    chk_reset("reset_init");
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 16; k++) begin
      step({2'b00, tbl[k].v}, {2'b00, tbl[k].r}, put(0, tbl[k].d));
      chk($sformatf("t2_press_%0d", k), 64'(pressure_out[3:0]), 64'(tbl[k].exp_p));
      chk($sformatf("t2_afull_%0d", k), 64'(afull_out[0]), 64'(tbl[k].exp_af));
      chk($sformatf("t2_full_%0d", k), 64'(full_out[0]), 64'(tbl[k].exp_f));
      chk($sformatf("t2_valid_%0d", k), 64'(valid_out[0]), 64'(tbl[k].exp_v));
      if (tbl[k].exp_v) chk($sformatf("t2_head_%0d", k), 64'(data_out[DW-1:0]), 64'(tbl[k].exp_h));
      chk($sformatf("t2_others_%0d", k), 64'(pressure_out[NP*PW-1:PW]), 64'(0));
    end
    step('0, '0, '0);

    // ch1 full: simultaneous pop and write keeps it full with no drop.
    for (int k = 0; k < 8; k++) step(3'b010, 3'b000, put(1, DW'(40'h100 + k)));
    step(3'b010, 3'b010, put(1, DW'(40'hAA)));
    chk("t3_press", 64'(pressure_out[7:4]), 64'(8));
    chk("t3_drop", 64'(drop_cnt[15:8]), 64'(0));
    for (int k = 0; k < 7; k++) step(3'b000, 3'b010, '0);
    chk("t3_tail", 64'(data_out[2*DW-1:DW]), 64'(40'hAA));
    step(3'b000, 3'b010, '0);

    // ch2 full: 300 rejected writes saturate the drop counter.
    for (int k = 0; k < 8; k++) step(3'b100, 3'b000, put(2, DW'(40'h200 + k)));
    for (int k = 0; k < 300; k++) step(3'b100, 3'b000, rand_data());
    chk("t4_drop_sat", 64'(drop_cnt[23:16]), 64'(255));
    chk("t4_press", 64'(pressure_out[11:8]), 64'(8));
    chk("t4_head", 64'(data_out[3*DW-1:2*DW]), 64'(40'h200));
    for (int k = 0; k < 8; k++) step(3'b000, 3'b100, '0);

    // count=1 with simultaneous push/pop: pointers wrap, count holds.
    step(3'b001, 3'b000, put(0, DW'(40'h300)));
    for (int k = 0; k < 10; k++) step(3'b001, 3'b001, put(0, DW'(40'h301 + k)));
    chk("t5_press", 64'(pressure_out[3:0]), 64'(1));
    chk("t5_head", 64'(data_out[DW-1:0]), 64'(40'h30A));
    step(3'b000, 3'b001, '0);

    // Empty ch0 with write and read in the same cycle.
    vin = 3'b001; rin = 3'b001; din = put(0, DW'(40'h55));
    #2;
    chk("t6_valid_same", 64'(valid_out[0]), 64'(BYP ? 1 : 0));
    check_model("t6");
    @(posedge clk); model_update(); #1;
    chk("t6_press", 64'(pressure_out[3:0]), 64'(BYP ? 0 : 1));
    vin = '0; rin = '0; din = '0;
    #2;
    chk("t6_valid_next", 64'(valid_out[0]), 64'(BYP ? 0 : 1));
    step(3'b000, 3'b001, '0);

    for (int k = 0; k < 1500; k++) begin
      int pw;
      logic [NP-1:0] v, r;
      pw = ((k / 100) % 2 == 1) ? 85 : 35;
      for (int c = 0; c < NP; c++) begin
        v[c] = ($urandom_range(0, 99) < pw);
        r[c] = ($urandom_range(0, 99) < (100 - pw));
      end
      step(v, r, rand_data());
    end

    // Asynchronous reset with traffic queued.
    for (int k = 0; k < 6; k++) step(3'b111, 3'b000, rand_data());
    vin = '0; rin = '0;
    #1 rst_n = 1'b0;
    #1 chk_reset("reset_mid");
    for (int c = 0; c < NP; c++) begin
      q[c].delete();
      drops[c] = 0;
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 200; k++) step($urandom_range(0, 7), $urandom_range(0, 7), rand_data());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
